transaction_arbiter_ctrl: RTL and testbench

- Controller/arbiter between the four input FIFOs (P0..P3) and the four output FIFOs (S0..S3) of the transaction layer.
- Owns the RESET/INIT/IDLE/ACTIVE state machine and latches and distributes the almost-full/almost-empty thresholds.
- Each cycle it selects one eligible input head word, pops it, and pushes it one cycle later into the output FIFO named by its destination field [9:8].

---
 rtl/transaction_arbiter_ctrl.sv | 163 ++++++++++++++++
 tb/tb_transaction_arbiter_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/transaction_arbiter_ctrl.sv
// Arbiter/controller between input FIFOs P0..P3 and output FIFOs S0..S3: owns the
// RESET/INIT/IDLE/ACTIVE FSM and threshold registers. Optional macro: ARB_ROUND_ROBIN_EN.
module transaction_arbiter_ctrl #(
    parameter int unsigned    WORD_SIZE    = 12,
    parameter int unsigned    PTR          = 3,
    parameter logic [PTR-1:0] FULL_TH_RST  = PTR'(3'b110),
    parameter logic [PTR-1:0] EMPTY_TH_RST = PTR'(3'b010)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [PTR-1:0]       full_threshold_in,
    input  logic [PTR-1:0]       empty_threshold_in,
    input  logic [3:0]           in_empty,
    input  logic [WORD_SIZE-1:0] in_data_P0,
    input  logic [WORD_SIZE-1:0] in_data_P1,
    input  logic [WORD_SIZE-1:0] in_data_P2,
    input  logic [WORD_SIZE-1:0] in_data_P3,
    input  logic [3:0]           out_almost_full,
    output logic [3:0]           pop_in,
    output logic [3:0]           push_out,
    output logic [WORD_SIZE-1:0] data_out,
    output logic [PTR-1:0]       full_threshold,
    output logic [PTR-1:0]       empty_threshold,
    output logic [1:0]           state,
    output logic                 idle
);

    localparam int unsigned NPORT    = 4;
    localparam int unsigned DEST_LSB = 8;

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_INIT   = 2'b01,
        ST_IDLE   = 2'b10,
        ST_ACTIVE = 2'b11
    } state_e;

    state_e               state_q, state_d;
    logic [PTR-1:0]       full_th_q, full_th_d;
    logic [PTR-1:0]       empty_th_q, empty_th_d;
    logic [NPORT-1:0]     push_q, push_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 idle_q, idle_d;

    logic [WORD_SIZE-1:0] in_word [NPORT];
    logic [NPORT-1:0]     eligible;
    logic                 arb_en;
    logic                 grant_valid;
    logic [1:0]           grant_idx;
    logic [1:0]           search_base;

    assign in_word[0] = in_data_P0;
    assign in_word[1] = in_data_P1;
    assign in_word[2] = in_data_P2;
    assign in_word[3] = in_data_P3;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    assign search_base = rr_ptr_q;
`else
    assign search_base = 2'd0;
`endif

    assign arb_en = (state_q == ST_ACTIVE) && !init;

    // A port may go only if it has a word and that word's destination can accept it
    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NPORT); i++) begin
            eligible[i] = !in_empty[i] && !out_almost_full[in_word[i][DEST_LSB +: 2]];
        end
    end

    // Scan downward from the far end so the port closest to search_base wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        for (int k = int'(NPORT) - 1; k >= 0; k--) begin
            if (arb_en && eligible[search_base + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = search_base + 2'(k);
            end
        end
    end

    assign pop_in = grant_valid ? (NPORT'(1) << grant_idx) : '0;

    always_comb begin
        state_d    = state_q;
        full_th_d  = full_th_q;
        empty_th_d = empty_th_q;
        push_d     = '0;
        data_d     = data_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    full_th_d  = full_threshold_in;
                    empty_th_d = empty_threshold_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init)              state_d = ST_INIT;
                else if (!(&in_empty)) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)           state_d = ST_INIT;
                else if (&in_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase

        // Popped word lands in its output FIFO one cycle later, even if the FSM leaves ACTIVE
        if (grant_valid) begin
            push_d = NPORT'(1) << in_word[grant_idx][DEST_LSB +: 2];
            data_d = in_word[grant_idx];
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_d = grant_idx + 2'd1;
`endif
        end

        idle_d = (state_d == ST_IDLE) && (push_d == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            full_th_q  <= FULL_TH_RST;
            empty_th_q <= EMPTY_TH_RST;
            push_q     <= '0;
            data_q     <= '0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            full_th_q  <= full_th_d;
            empty_th_q <= empty_th_d;
            push_q     <= push_d;
            data_q     <= data_d;
            idle_q     <= idle_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rr_ptr_q <= 2'd0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    assign push_out        = push_q;
    assign data_out        = data_q;
    assign full_threshold  = full_th_q;
    assign empty_threshold = empty_th_q;
    assign state           = state_q;
    assign idle            = idle_q;

endmodule

// File: tb/tb_transaction_arbiter_ctrl.sv
// Bench for transaction_arbiter_ctrl: per-cycle behavioural model comparison plus
// hand-computed expectations for the reset/init, transfer, priority, backpressure cases.
module tb_transaction_arbiter_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [2:0]  fth_in, eth_in;
    logic [3:0]  in_empty, oaf;
    logic [11:0] d0, d1, d2, d3;
    logic [3:0]  pop_in, push_out;
    logic [11:0] data_out;
    logic [2:0]  full_th, empty_th;
    logic [1:0]  state;
    logic        idle;

    transaction_arbiter_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .init              (init),
        .full_threshold_in (fth_in),
        .empty_threshold_in(eth_in),
        .in_empty          (in_empty),
        .in_data_P0        (d0),
        .in_data_P1        (d1),
        .in_data_P2        (d2),
        .in_data_P3        (d3),
        .out_almost_full   (oaf),
        .pop_in            (pop_in),
        .push_out          (push_out),
        .data_out          (data_out),
        .full_threshold    (full_th),
        .empty_threshold   (empty_th),
        .state             (state),
        .idle              (idle)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: state as 0..3 (RESET, INIT, IDLE, ACTIVE), pending push and word, thresholds
    int          m_state = 0, nxt_state = 0;
    logic [2:0]  m_full = 3'd6, nxt_full = 3'd6;
    logic [2:0]  m_empty = 3'd2, nxt_empty = 3'd2;
    logic [3:0]  m_push = 4'd0, nxt_push = 4'd0;
    logic [11:0] m_data = 12'd0, nxt_data = 12'd0;
    int          m_rr = 0, nxt_rr = 0;

    // Hand-computed expectations for the current cycle, set by the stimulus
    logic        lit_state_en = 1'b0, lit_pop_en = 1'b0, lit_push_en = 1'b0;
    logic        lit_th_en = 1'b0, lit_idle_en = 1'b0;
    int          lit_state = 0;
    logic [3:0]  lit_pop = 4'd0, lit_push = 4'd0;
    logic [11:0] lit_data = 12'd0;
    logic [2:0]  lit_full = 3'd0, lit_empty = 3'd0;
    logic        lit_idle = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [11:0] w [4];
    int          gi;
    logic [3:0]  epop;

    always @(negedge clk) begin : compare
        if (!reset) begin
            chk("rst_state", int'(state), 0);
            chk("rst_pop", int'(pop_in), 0);
            chk("rst_push", int'(push_out), 0);
            chk("rst_data", int'(data_out), 0);
            chk("rst_idle", int'(idle), 0);
            chk("rst_full_th", int'(full_th), 6);
            chk("rst_empty_th", int'(empty_th), 2);
            nxt_state <= 0;
            nxt_full  <= 3'd6;
            nxt_empty <= 3'd2;
            nxt_push  <= 4'd0;
            nxt_data  <= 12'd0;
            nxt_rr    <= 0;
        end else begin
            w[0] = d0; w[1] = d1; w[2] = d2; w[3] = d3;
            gi = -1;
            if (m_state == 3 && !init) begin
                for (int k = 0; k < 4; k++) begin
                    if (gi < 0 && !in_empty[(m_rr + k) % 4] && !oaf[w[(m_rr + k) % 4][9:8]])
                        gi = (m_rr + k) % 4;
                end
            end
            epop = (gi >= 0) ? 4'(1 << gi) : 4'd0;

            chk("state", int'(state), m_state);
            chk("pop_in", int'(pop_in), int'(epop));
            chk("push_out", int'(push_out), int'(m_push));
            if (m_push != 4'd0) chk("data_out", int'(data_out), int'(m_data));
            chk("full_th", int'(full_th), int'(m_full));
            chk("empty_th", int'(empty_th), int'(m_empty));
            chk("idle", int'(idle), (m_state == 2 && m_push == 4'd0) ? 1 : 0);

            case (m_state)
                0: nxt_state <= 1;
                1: nxt_state <= init ? 1 : 2;
                2: nxt_state <= init ? 1 : ((in_empty != 4'hF) ? 3 : 2);
                default: nxt_state <= init ? 1 : ((in_empty == 4'hF) ? 2 : 3);
            endcase
            if (m_state == 1 && init) begin
                nxt_full  <= fth_in;
                nxt_empty <= eth_in;
            end else begin
                nxt_full  <= m_full;
                nxt_empty <= m_empty;
            end
            if (gi >= 0) begin
                nxt_push <= 4'(1 << w[gi][9:8]);
                nxt_data <= w[gi];
`ifdef ARB_ROUND_ROBIN_EN
                nxt_rr   <= (gi + 1) % 4;
`else
                nxt_rr   <= m_rr;
`endif
            end else begin
                nxt_push <= 4'd0;
                nxt_data <= m_data;
                nxt_rr   <= m_rr;
            end
        end

        if (lit_state_en) chk("lit_state", int'(state), lit_state);
        if (lit_pop_en)   chk("lit_pop", int'(pop_in), int'(lit_pop));
        if (lit_push_en) begin
            chk("lit_push", int'(push_out), int'(lit_push));
            chk("lit_data", int'(data_out), int'(lit_data));
        end
        if (lit_th_en) begin
            chk("lit_full_th", int'(full_th), int'(lit_full));
            chk("lit_empty_th", int'(empty_th), int'(lit_empty));
        end
        if (lit_idle_en)  chk("lit_idle", int'(idle), int'(lit_idle));
    end

    always @(posedge clk) begin : model_advance
        m_state <= nxt_state;
        m_full  <= nxt_full;
        m_empty <= nxt_empty;
        m_push  <= nxt_push;
        m_data  <= nxt_data;
        m_rr    <= nxt_rr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        lit_state_en = 1'b0; lit_pop_en = 1'b0; lit_push_en = 1'b0;
        lit_th_en = 1'b0; lit_idle_en = 1'b0;
    endtask

    task automatic e_state(input int s);
        lit_state_en = 1'b1; lit_state = s;
    endtask
    task automatic e_pop(input logic [3:0] p);
        lit_pop_en = 1'b1; lit_pop = p;
    endtask
    task automatic e_push(input logic [3:0] p, input logic [11:0] dat);
        lit_push_en = 1'b1; lit_push = p; lit_data = dat;
    endtask
    task automatic e_th(input logic [2:0] f, input logic [2:0] e);
        lit_th_en = 1'b1; lit_full = f; lit_empty = e;
    endtask
    task automatic e_idle(input logic v);
        lit_idle_en = 1'b1; lit_idle = v;
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; fth_in = 3'd5; eth_in = 3'd3;
        in_empty = 4'hF; oaf = 4'h0;
        d0 = 12'h0; d1 = 12'h0; d2 = 12'h0; d3 = 12'h0;

        // Reset and threshold programming
        tick(); e_state(0); e_th(3'd6, 3'd2);
        tick(); init = 1'b1; e_state(0); e_th(3'd6, 3'd2);
        tick(); reset = 1'b1; init = 1'b0; fth_in = 3'd6; eth_in = 3'd2; e_state(0);
        tick(); init = 1'b1; e_state(1); e_th(3'd6, 3'd2);
        tick(); fth_in = 3'd7; eth_in = 3'd1; e_state(1); e_th(3'd6, 3'd2);
        tick(); init = 1'b0; fth_in = 3'd3; eth_in = 3'd4; e_state(1); e_th(3'd7, 3'd1);

        // Single transfer from P2
        tick(); d2 = 12'hA5C; in_empty = 4'b1011; e_state(2); e_idle(1'b1); e_th(3'd7, 3'd1);
        tick(); e_state(3); e_pop(4'b0100);
        tick(); in_empty = 4'hF; e_state(3); e_pop(4'b0000); e_push(4'b0100, 12'hA5C);
        tick(); e_state(2); e_idle(1'b1); e_push(4'b0000, 12'hA5C);

        // Priority with all four ports loaded
        tick(); d0 = 12'h711; d1 = 12'hA22; d2 = 12'h133; d3 = 12'hC44; in_empty = 4'b0000;
        e_state(2);
        tick(); e_state(3);
`ifndef ARB_ROUND_ROBIN_EN
        e_pop(4'b0001);
`endif
        tick(); in_empty = 4'b0001;
`ifndef ARB_ROUND_ROBIN_EN
        e_pop(4'b0010); e_push(4'b1000, 12'h711);
`endif
        tick(); in_empty = 4'b0011;
`ifndef ARB_ROUND_ROBIN_EN
        e_pop(4'b0100); e_push(4'b0100, 12'hA22);
`endif
        tick(); in_empty = 4'b0111;
`ifndef ARB_ROUND_ROBIN_EN
        e_pop(4'b1000); e_push(4'b0010, 12'h133);
`endif
        tick(); in_empty = 4'hF; e_state(3);
`ifndef ARB_ROUND_ROBIN_EN
        e_push(4'b0001, 12'hC44);
`endif
        tick(); e_state(2); e_idle(1'b1);

        // Backpressure on S0: P1 goes around blocked P0
        tick(); d0 = 12'h05A; d1 = 12'h5B7; in_empty = 4'b1100; oaf = 4'b0001; e_state(2);
        tick(); e_state(3); e_pop(4'b0010);
        tick(); in_empty = 4'b1110; e_pop(4'b0000); e_push(4'b0010, 12'h5B7);
        tick(); e_pop(4'b0000); e_state(3);
        tick(); oaf = 4'b0000; e_pop(4'b0001);
        tick(); in_empty = 4'hF; e_pop(4'b0000); e_push(4'b0001, 12'h05A);
        tick(); e_state(2); e_idle(1'b1);

        // init while ACTIVE, right after a grant
        tick(); d1 = 12'h1E4; d3 = 12'hAC3; in_empty = 4'b0101; e_state(2);
        tick(); e_state(3); e_pop(4'b0010);
        tick(); in_empty = 4'b0111; init = 1'b1; fth_in = 3'd5; eth_in = 3'd3;
        e_state(3); e_pop(4'b0000); e_push(4'b0010, 12'h1E4);
        tick(); e_state(1); e_push(4'b0000, 12'h1E4); e_th(3'd7, 3'd1);
        tick(); init = 1'b0; e_state(1); e_th(3'd5, 3'd3);
        tick(); e_state(2); e_idle(1'b1);
        tick(); e_state(3); e_pop(4'b1000);

        // Reset right after a pop: pending push is dropped
        tick(); reset = 1'b0; in_empty = 4'hF;
        e_state(0); e_pop(4'b0000); e_push(4'b0000, 12'h000); e_th(3'd6, 3'd2); e_idle(1'b0);
        tick(); reset = 1'b1; e_state(0);
        tick(); e_state(1);
        tick(); e_state(2); e_idle(1'b1);
        tick();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
